// File: rtl/cordic_pkg.sv
// Shared Q9.12 CORDIC constants and controller state encoding.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package cordic_pkg;

  localparam int WIDTH     = 22;
  localparam int FRAC_BITS = 12;
  localparam int INT_BITS  = WIDTH - FRAC_BITS - 1;
  localparam int ITERS     = INT_BITS + FRAC_BITS + 1;

  // Saturation limits of the signed Q9.12 result
  localparam logic signed [WIDTH-1:0] Q_MAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic signed [WIDTH-1:0] Q_MIN = {1'b1, {(WIDTH-1){1'b0}}};

  // Same encoding as the linear-rotation multiplier controller
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    DONE = 2'b10
  } state_t;

endpackage

// File: rtl/cordic_linvec_step.sv
// One linear-vectoring CORDIC iteration: drives y toward 0, accumulates y/x into z.
// Latency: purely combinational.
// Backpressure: none; the caller sequences the iteration index.
module cordic_linvec_step
  import cordic_pkg::*;
#(
  parameter int XW    = 34,
  parameter int ZW    = 24,
  parameter int IW    = 6,
  parameter int FBITS = FRAC_BITS
) (
  input  logic signed [XW-1:0] x,
  input  logic signed [XW-1:0] y,
  input  logic signed [ZW-1:0] z,
  input  logic signed [IW-1:0] i,
  output logic signed [XW-1:0] y_next,
  output logic signed [ZW-1:0] z_next
);

  logic [IW-1:0]        x_amt;
  logic [IW-1:0]        w_amt;
  logic signed [XW-1:0] x_sh;
  logic signed [ZW-1:0] w;
  logic                 same_sign;

  // Scale x by 2^-i, pick the direction from the sign of y relative to x
  always_comb begin
    x_amt     = i[IW-1] ? IW'(-i) : IW'(i);
    x_sh      = i[IW-1] ? (x << x_amt) : (x >>> x_amt);
    w_amt     = IW'(FBITS) - IW'(i);
    w         = {{(ZW-1){1'b0}}, 1'b1} << w_amt;
    // y == 0 is treated as positive
    same_sign = (y[XW-1] == x[XW-1]);
    y_next    = same_sign ? (y - x_sh) : (y + x_sh);
    z_next    = same_sign ? (z + w) : (z - w);
  end

endmodule

// File: rtl/cordic_divider.sv
// Iterative Q9.12 divider, quotient = dividend / divisor, one CORDIC iteration per clock.
// Latency: done 23 edges after start is sampled (1 edge for divide by zero).
// Backpressure: start is ignored while busy; no queueing.
module cordic_divider
  import cordic_pkg::*;
#(
  parameter int WIDTH     = cordic_pkg::WIDTH,
  parameter int FRAC_BITS = cordic_pkg::FRAC_BITS,
  parameter int INT_BITS  = cordic_pkg::INT_BITS,
  parameter int ITERS     = cordic_pkg::ITERS
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic signed [WIDTH-1:0] dividend,
  input  logic signed [WIDTH-1:0] divisor,
  output logic                    busy,
  output logic                    done,
  output logic signed [WIDTH-1:0] quotient,
  output logic                    div_by_zero,
  output logic                    overflow
);

  // Guard bits let x << INT_BITS and the running y stay exact
  localparam int XW     = WIDTH + INT_BITS + 3;
  localparam int ZW     = WIDTH + 2;
  localparam int IW     = 6;
  localparam int I_LAST = ITERS - INT_BITS - 1;

  localparam logic signed [ZW-1:0]    Z_HI = ZW'((1 << (WIDTH-1)) - 1);
  localparam logic signed [ZW-1:0]    Z_LO = -ZW'(1 << (WIDTH-1));
  localparam logic signed [WIDTH-1:0] R_HI = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic signed [WIDTH-1:0] R_LO = {1'b1, {(WIDTH-1){1'b0}}};

  state_t               state;
  logic signed [XW-1:0] x_r;
  logic signed [XW-1:0] y_r;
  logic signed [ZW-1:0] z_r;
  logic signed [IW-1:0] i_r;
  logic                 dbz_r;
  logic signed [XW-1:0] y_nx;
  logic signed [ZW-1:0] z_nx;

  cordic_linvec_step #(
    .XW    (XW),
    .ZW    (ZW),
    .IW    (IW),
    .FBITS (FRAC_BITS)
  ) u_step (
    .x      (x_r),
    .y      (y_r),
    .z      (z_r),
    .i      (i_r),
    .y_next (y_nx),
    .z_next (z_nx)
  );

  // Controller and datapath registers; result and flags only move in DONE
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      x_r         <= '0;
      y_r         <= '0;
      z_r         <= '0;
      i_r         <= '0;
      dbz_r       <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            x_r   <= {{(XW-WIDTH){divisor[WIDTH-1]}}, divisor};
            y_r   <= {{(XW-WIDTH){dividend[WIDTH-1]}}, dividend};
            z_r   <= '0;
            i_r   <= IW'(-INT_BITS);
            busy  <= 1'b1;
            dbz_r <= (divisor == '0);
            state <= (divisor == '0) ? DONE : CALC;
          end
        end
        CALC: begin
          y_r <= y_nx;
          z_r <= z_nx;
          i_r <= i_r + IW'(1);
          if (i_r == IW'(I_LAST)) state <= DONE;
        end
        DONE: begin
          done        <= 1'b1;
          busy        <= 1'b0;
          state       <= IDLE;
          div_by_zero <= dbz_r;
          if (dbz_r) begin
            // y still holds the dividend: saturate toward its sign
            quotient <= y_r[XW-1] ? R_LO : R_HI;
            overflow <= 1'b0;
          end else if (z_r > Z_HI) begin
            quotient <= R_HI;
            overflow <= 1'b1;
          end else if (z_r < Z_LO) begin
            quotient <= R_LO;
            overflow <= 1'b1;
          end else begin
            quotient <= z_r[WIDTH-1:0];
            overflow <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cordic_divider.sv
// Self-checking bench for cordic_divider: directed cases plus random vectors
// against a real-arithmetic reference quotient.
module tb_cordic_divider;
  import cordic_pkg::*;

  logic                    clk;
  logic                    rst;
  logic                    start;
  logic signed [WIDTH-1:0] dividend;
  logic signed [WIDTH-1:0] divisor;
  logic                    busy;
  logic                    done;
  logic signed [WIDTH-1:0] quotient;
  logic                    div_by_zero;
  logic                    overflow;

  int n_checks = 0;
  int n_fail   = 0;

  cordic_divider dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .div_by_zero (div_by_zero),
    .overflow    (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input longint got, input longint exp, input longint tol);
    n_checks++;
    if (got > exp + tol || got < exp - tol) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (tol %0d)", tag, got, exp, tol);
    end
  endtask

  // Reference: 0 in range (+/-2 LSB), 1 sat high, 2 sat low, 3 divide by zero,
  // 4 too close to a saturation limit to call
  function automatic int ref_model(input int dvd, input int dvs, output longint q);
    real r;
    longint qmax, qmin;
    qmax = longint'(Q_MAX);
    qmin = longint'(Q_MIN);
    q = 0;
    if (dvs == 0) begin
      q = (dvd >= 0) ? qmax : qmin;
      return 3;
    end
    r = $itor(dvd) * 4096.0 / $itor(dvs);
    if (r > $itor(qmax) + 8.0) begin q = qmax; return 1; end
    if (r < $itor(qmin) - 8.0) begin q = qmin; return 2; end
    if (r < $itor(qmax) - 8.0 && r > $itor(qmin) + 8.0) begin
      q = longint'(r);
      return 0;
    end
    return 4;
  endfunction

  // Launch one division from an idle negedge and check result, flags and timing
  task automatic run_op(input string tag, input int dvd, input int dvs);
    int     cls;
    int     lat;
    longint eq;
    cls      = ref_model(dvd, dvs, eq);
    dividend = WIDTH'(dvd);
    divisor  = WIDTH'(dvs);
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check({tag, ".busy"}, longint'(busy), 1, 0);
    lat = 0;
    while (!done && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check({tag, ".latency"}, lat, (dvs == 0) ? 1 : ITERS + 1, 0);
    check({tag, ".quotient"}, longint'(quotient), eq, (cls == 0) ? 2 : 0);
    check({tag, ".dbz"}, longint'(div_by_zero), (cls == 3) ? 1 : 0, 0);
    check({tag, ".ovf"}, longint'(overflow), (cls == 1 || cls == 2) ? 1 : 0, 0);
    @(negedge clk);
    check({tag, ".done_pulse"}, longint'(done), 0, 0);
    check({tag, ".busy_after"}, longint'(busy), 0, 0);
  endtask

  initial begin
    int     dvd, dvs, mode, ndone, cls;
    longint eq;

    rst      = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    #3;
    check("reset.busy", longint'(busy), 0, 0);
    check("reset.done", longint'(done), 0, 0);
    check("reset.quotient", longint'(quotient), 0, 0);
    check("reset.dbz", longint'(div_by_zero), 0, 0);
    check("reset.ovf", longint'(overflow), 0, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    run_op("div_3_1p5", 12288, 6144);
    run_op("div_m5p25_2", -21504, 8192);
    run_op("div_5p25_m2", 21504, -8192);
    run_op("ovf_500_0p5", 2048000, 2048);
    run_op("zero_dividend", 0, 12288);
    run_op("dbz_pos", 100, 0);
    run_op("dbz_neg", -100, 0);

    // Extra starts at cycle 5 (CALC) and cycle 23 (DONE) must be ignored
    dividend = 22'sd12288;
    divisor  = 22'sd6144;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    ndone = 0;
    for (int c = 1; c <= ITERS + 1; c++) begin
      dividend = 22'sd4096;
      divisor  = 22'sd4096;
      start    = (c == 5 || c == ITERS + 1);
      @(negedge clk);
      start = 1'b0;
      if (done) ndone++;
    end
    check("hs.done_at_23", longint'(done), 1, 0);
    check("hs.done_count", ndone, 1, 0);
    check("hs.quotient", longint'(quotient), 8192, 2);
    // Cycle 24 is IDLE: this start must be accepted
    dividend = 22'sd4096;
    divisor  = 22'sd16384;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("hs.accept_24", longint'(busy), 1, 0);
    ndone = 0;
    while (!done && ndone < 40) begin
      @(negedge clk);
      ndone++;
    end
    check("hs.second_latency", ndone, ITERS + 1, 0);
    check("hs.second_quotient", longint'(quotient), 1024, 2);
    @(negedge clk);

    // Leave nonzero quotient/flags, then abort a running operation
    run_op("dbz_before_rst", -100, 0);
    dividend = 22'sd12288;
    divisor  = 22'sd6144;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrst.busy", longint'(busy), 0, 0);
    check("midrst.done", longint'(done), 0, 0);
    check("midrst.quotient", longint'(quotient), 0, 0);
    check("midrst.dbz", longint'(div_by_zero), 0, 0);
    check("midrst.ovf", longint'(overflow), 0, 0);
    @(negedge clk);
    rst = 1'b0;
    ndone = 0;
    repeat (30) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check("midrst.no_done", ndone, 0, 0);
    run_op("after_rst_1_4", 4096, 16384);

    // Random vectors; divisors are either large or whole numbers so the
    // truncated shifts stay inside the accuracy bound
    repeat (150) begin
      do begin
        mode = int'($urandom_range(0, 3));
        dvd  = int'($urandom_range(0, (1 << 22) - 1)) - (1 << 21);
        case (mode)
          0: dvs = int'($urandom_range((1 << 21) - 1, 1 << 17));
          1: dvs = int'($urandom_range(511, 1)) << 12;
          2: begin
            dvs = int'($urandom_range(511, 1)) << 12;
            dvd = int'($urandom_range(200, 0)) - 100;
          end
          default: dvs = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range((1 << 21) - 1, 1 << 17));
        endcase
        if ($urandom_range(0, 1) == 1) dvs = -dvs;
        cls = ref_model(dvd, dvs, eq);
      end while (cls == 4);
      run_op("rand", dvd, dvs);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

  // Hard stop in case the stimulus itself stalls
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
